// File: rtl/str_op_pkg.sv
// Shared types for the string operation sequencer: operation codes, FSM states
// and the ASCII lower-case helper used by the optional case-folded palindrome compare.
package str_op_pkg;

    typedef enum logic [1:0] {
        OP_PASS = 2'd0,
        OP_REV  = 2'd1,
        OP_ROT  = 2'd2,
        OP_PAL  = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StProc,
        StEmit,
        StReport
    } state_e;

    function automatic logic [7:0] to_lower(input logic [7:0] c);
        if (c >= 8'h41 && c <= 8'h5a) begin
            return c + 8'h20;
        end
        return c;
    endfunction

endpackage

// File: rtl/str_buf.sv
// Character buffer: MAX_LEN x CW storage with one write port and two
// combinational read ports. Contents are deliberately not reset.
module str_buf #(
    parameter int unsigned MAX_LEN = 32,
    parameter int unsigned CW      = 8,
    localparam int unsigned AW     = $clog2(MAX_LEN)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [CW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_a_i,
    output logic [CW-1:0] rdata_a_o,
    input  logic [AW-1:0] raddr_b_i,
    output logic [CW-1:0] rdata_b_o
);

    logic [CW-1:0] mem_q [MAX_LEN];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/str_op_sequencer.sv
// Loads a character string, then passes, reverses, rotates or palindrome-checks it.
// Define STR_CASE_FOLD_EN to make the palindrome compare ignore ASCII letter case.
module str_op_sequencer
    import str_op_pkg::*;
#(
    parameter int unsigned MAX_LEN = 32,
    parameter int unsigned CW      = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CW-1:0]                in_data,
    input  logic                         in_last,
    input  logic [1:0]                   op,
    input  logic [$clog2(MAX_LEN):0]     rot_k,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CW-1:0]                out_data,
    output logic                         out_last,
    output logic                         pal_valid,
    output logic                         pal_ok,
    output logic [$clog2(MAX_LEN):0]     len_o,
    output logic                         busy,
    output logic                         err
);

    localparam int unsigned AW = $clog2(MAX_LEN);
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] MaxLen = LW'(MAX_LEN);

    state_e        state_q, state_d;
    op_e           op_q, op_d;
    logic [LW-1:0] k_q, k_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] idx_q, idx_d;
    logic          err_q, err_d;
    logic          pal_ok_q, pal_ok_d;

    logic          we;
    logic [AW-1:0] waddr, raddr_a, raddr_b;
    logic [CW-1:0] rd_a, rd_b, cmp_a, cmp_b;
    logic [LW-1:0] rot_sum, last_idx;
    logic          pal_eq;

    str_buf #(
        .MAX_LEN (MAX_LEN),
        .CW      (CW)
    ) u_buf (
        .clk_i     (clk),
        .we_i      (we),
        .waddr_i   (waddr),
        .wdata_i   (in_data),
        .raddr_a_i (raddr_a),
        .rdata_a_o (rd_a),
        .raddr_b_i (raddr_b),
        .rdata_b_o (rd_b)
    );

    // Port A serves the emit index and the low palindrome index; port B the mirror index.
    always_comb begin
        last_idx = len_q - LW'(1);
        rot_sum  = idx_q + k_q;
        raddr_a  = idx_q[AW-1:0];
        raddr_b  = AW'(last_idx - idx_q);
        if (state_q == StEmit) begin
            unique case (op_q)
                OP_REV:  raddr_a = AW'(last_idx - idx_q);
                OP_ROT:  raddr_a = AW'((rot_sum >= len_q) ? rot_sum - len_q : rot_sum);
                default: raddr_a = idx_q[AW-1:0];
            endcase
        end
    end

    always_comb begin
        cmp_a = rd_a;
        cmp_b = rd_b;
`ifdef STR_CASE_FOLD_EN
        cmp_a[7:0] = to_lower(rd_a[7:0]);
        cmp_b[7:0] = to_lower(rd_b[7:0]);
`endif
        pal_eq = (cmp_a == cmp_b);
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        k_d      = k_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        err_d    = err_q;
        pal_ok_d = pal_ok_q;
        we       = 1'b0;
        waddr    = cnt_q[AW-1:0];

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    we    = 1'b1;
                    waddr = '0;
                    cnt_d = LW'(1);
                    op_d  = op_e'(op);
                    k_d   = rot_k;
                    err_d = 1'b0;
                    idx_d = '0;
                    if (in_last) begin
                        len_d   = LW'(1);
                        state_d = StProc;
                    end else begin
                        state_d = StLoad;
                    end
                end
            end
            StLoad: begin
                if (in_valid) begin
                    // Beats past a full buffer are swallowed and flagged.
                    if (cnt_q < MaxLen) begin
                        we    = 1'b1;
                        cnt_d = cnt_q + LW'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                    if (in_last) begin
                        len_d   = cnt_d;
                        idx_d   = '0;
                        state_d = StProc;
                    end
                end
            end
            StProc: begin
                unique case (op_q)
                    OP_ROT: begin
                        if (k_q >= len_q) begin
                            k_d = k_q - len_q;
                        end else begin
                            state_d = StEmit;
                        end
                    end
                    OP_PAL: begin
                        if (!pal_eq) begin
                            pal_ok_d = 1'b0;
                            state_d  = StReport;
                        end else if (idx_q + LW'(1) >= (len_q >> 1)) begin
                            pal_ok_d = 1'b1;
                            state_d  = StReport;
                        end else begin
                            idx_d = idx_q + LW'(1);
                        end
                    end
                    default: state_d = StEmit;
                endcase
            end
            StEmit: begin
                if (out_ready) begin
                    if (idx_q == last_idx) begin
                        state_d = StIdle;
                    end else begin
                        idx_d = idx_q + LW'(1);
                    end
                end
            end
            StReport: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            op_q     <= OP_PASS;
            k_q      <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            err_q    <= 1'b0;
            pal_ok_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            k_q      <= k_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            err_q    <= err_d;
            pal_ok_q <= pal_ok_d;
        end
    end

    assign in_ready  = rst_n && (state_q == StIdle || state_q == StLoad);
    assign out_valid = (state_q == StEmit);
    assign out_data  = out_valid ? rd_a : '0;
    assign out_last  = out_valid && (idx_q == last_idx);
    assign pal_valid = (state_q == StReport);
    assign pal_ok    = pal_ok_q;
    assign len_o     = len_q;
    assign busy      = (state_q == StProc) || (state_q == StEmit) || (state_q == StReport);
    assign err       = err_q;

endmodule

// File: tb/tb_str_op_sequencer.sv
// Self-checking bench for str_op_sequencer: directed cases plus randomized strings
// checked against a queue-based reference model of the string operations.
module tb_str_op_sequencer;

    localparam int MAX_LEN = 32;
    localparam int CW      = 8;
    localparam int LW      = $clog2(MAX_LEN) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic [1:0]    op = '0;
    logic [LW-1:0] rot_k = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] out_data;
    logic          out_last;
    logic          pal_valid;
    logic          pal_ok;
    logic [LW-1:0] len_o;
    logic          busy;
    logic          err;

    str_op_sequencer #(
        .MAX_LEN (MAX_LEN),
        .CW      (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .op        (op),
        .rot_k     (rot_k),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .pal_valid (pal_valid),
        .pal_ok    (pal_ok),
        .len_o     (len_o),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] in_q[$];
    logic [7:0] exp_q[$];
    int         exp_len;
    int         exp_proc;
    bit         exp_pal;
    bit         exp_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] fold(input logic [7:0] c);
`ifdef STR_CASE_FOLD_EN
        if (c >= 8'h41 && c <= 8'h5a) return c + 8'h20;
`endif
        return c;
    endfunction

    task automatic set_str(input string s);
        in_q.delete();
        for (int i = 0; i < s.len(); i++) in_q.push_back(s[i]);
    endtask

    task automatic build_model(input int opc, input int k);
        int n;
        n = (in_q.size() > MAX_LEN) ? MAX_LEN : in_q.size();
        exp_q.delete();
        exp_len  = n;
        exp_err  = (in_q.size() > MAX_LEN);
        exp_proc = 1;
        exp_pal  = 1'b0;
        case (opc)
            0: for (int j = 0; j < n; j++) exp_q.push_back(in_q[j]);
            1: for (int j = 0; j < n; j++) exp_q.push_back(in_q[n-1-j]);
            2: begin
                for (int j = 0; j < n; j++) exp_q.push_back(in_q[(j + k) % n]);
                exp_proc = k / n + 1;
            end
            default: begin
                exp_pal  = 1'b1;
                exp_proc = (n < 2) ? 1 : n / 2;
                for (int i = 0; i < n / 2; i++) begin
                    if (fold(in_q[i]) != fold(in_q[n-1-i])) begin
                        exp_pal  = 1'b0;
                        exp_proc = i + 1;
                        break;
                    end
                end
            end
        endcase
    endtask

    task automatic send(input int opc, input int k);
        for (int i = 0; i < in_q.size(); i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = in_q[i];
            in_last  = (i == in_q.size() - 1);
            op       = opc[1:0];
            rot_k    = k[LW-1:0];
            if (!in_ready) check("in_ready", in_ready, 1);
            @(posedge clk);
            #1;
            if (i == 0) check("err_clear", err, 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // mode: 0 always ready, 1 toggling ready, 2 random ready
    task automatic collect(input int opc, input int mode);
        int cyc = 0, proc = 0, got = 0;
        bit done = 0, stalled = 0, first = 1;
        logic [7:0] hold_d = '0;
        logic hold_l = 1'b0;
        while (!done && cyc < 400) begin
            if (opc == 3) begin
                if (pal_valid) begin
                    check("pal_ok", pal_ok, exp_pal);
                    check("pal_cycles", proc, exp_proc);
                    done = 1;
                end else begin
                    proc++;
                end
            end else if (!out_valid) begin
                proc++;
            end else begin
                if (first) begin
                    check("proc_cycles", proc, exp_proc);
                    first = 0;
                end
                if (stalled) begin
                    check("stall_data", out_data, hold_d);
                    check("stall_last", out_last, hold_l);
                end
                case (mode)
                    0:       out_ready = 1'b1;
                    1:       out_ready = ~out_ready;
                    default: out_ready = 1'($urandom_range(0, 1));
                endcase
                if (out_ready) begin
                    check("data", out_data, exp_q[got]);
                    check("last", out_last, got == exp_q.size() - 1);
                    if (got == exp_q.size() - 1) done = 1;
                    got++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    hold_d  = out_data;
                    hold_l  = out_last;
                end
            end
            @(negedge clk);
            cyc++;
        end
        if (!done) check("timeout", 0, 1);
        check("idle_after", {busy, out_valid, pal_valid}, 0);
        if (opc == 3) check("pal_hold", pal_ok, exp_pal);
        check("len_o", len_o, exp_len);
        check("err", err, exp_err);
    endtask

    task automatic run(input int opc, input int k, input int mode);
        build_model(opc, k);
        send(opc, k);
        collect(opc, mode);
    endtask

    initial begin
        int n, opc, k;
        logic [7:0] c;

        #12;
        check("rst_in_ready", in_ready, 0);
        check("rst_outs", {out_valid, out_last, pal_valid, pal_ok, busy, err}, 0);
        check("rst_out_data", out_data, 0);
        check("rst_len", len_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("in_ready_release", in_ready, 1);

        set_str("Hello");  run(1, 0, 0);
        set_str("System"); run(2, 2, 2);
        set_str("System"); run(2, 8, 0);
        set_str("System"); run(2, 6, 0);
        set_str("Madam");  run(3, 0, 0);
        set_str("abca");   run(3, 0, 0);
        set_str("ABCD");   out_ready = 1'b0; run(0, 0, 1);

        in_q.delete();
        for (int i = 0; i < 33; i++) in_q.push_back(8'h41 + 8'(i % 26));
        run(0, 0, 2);

        // Reset in the middle of emitting.
        set_str("ABCD");
        build_model(0, 0);
        send(0, 0);
        out_ready = 1'b1;
        for (int w = 0; w < 10 && !out_valid; w++) @(negedge clk);
        check("emit_started", out_valid, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_rst_release", in_ready, 1);
        set_str("xy"); run(1, 0, 2);

        for (int r = 0; r < 24; r++) begin
            n   = $urandom_range(1, 36);
            opc = $urandom_range(0, 3);
            k   = $urandom_range(0, (2 * n > 63) ? 63 : 2 * n);
            in_q.delete();
            for (int i = 0; i < n; i++) begin
                c = 8'h61 + 8'($urandom_range(0, 2));
                if ($urandom_range(0, 1) == 1) c = c ^ 8'h20;
                in_q.push_back(c);
            end
            if (opc == 3 && $urandom_range(0, 1) == 1) begin
                for (int i = 0; i < n / 2; i++) begin
                    in_q[n-1-i] = in_q[i];
                    if ($urandom_range(0, 3) == 0) in_q[n-1-i] = in_q[i] ^ 8'h20;
                end
            end
            if (opc == 2 && n > MAX_LEN && k > 63) k = 63;
            run(opc, k, 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/str_op_sequencer.md
STR_OP_SEQUENCER -- requirements
Module: str_op_sequencer

Interface
REQ-001 SHALL have parameter MAX_LEN, default 32: buffer depth in characters; must be a power of two and at least 2.
REQ-002 SHALL have parameter CW, default 8: character width in bits.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_data (input, CW), in_last (input, 1): character input stream.
REQ-007 SHALL have port op, input, 2 bits: 0=pass, 1=reverse, 2=rotate-left, 3=palindrome check.
REQ-008 SHALL have port rot_k, input, $clog2(MAX_LEN)+1 bits: rotate amount.
REQ-009 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, CW), out_last (output, 1): result stream.
REQ-010 SHALL have ports pal_valid (output, 1), pal_ok (output, 1): palindrome result.
REQ-011 SHALL have ports len_o (output, $clog2(MAX_LEN)+1), busy (output, 1), err (output, 1).

Function
REQ-012 SHALL use an FSM with states IDLE, LOAD, PROC, EMIT and REPORT.
REQ-013 IDLE: in_ready=1; the first in_valid&&in_ready beat stores the character at index 0, latches op and rot_k, and moves to LOAD (or straight to PROC if in_last is set).
REQ-014 LOAD: in_ready=1 while fewer than MAX_LEN characters are stored; each beat stores at the next index.
REQ-015 A beat with in_last=1 SHALL set len_o to the stored count (1..MAX_LEN) and move to PROC on the next cycle.
REQ-016 Overflow: beats arriving when MAX_LEN characters are already stored SHALL be accepted and discarded, set err sticky and leave len_o=MAX_LEN; the transition to PROC still occurs on in_last.
REQ-017 PROC, rotate: reduce k to k mod len by subtracting len once per cycle until k<len; exit when k<len.
REQ-018 PROC, palindrome: compare buf[i] with buf[len-1-i] one pair per cycle for i=0..len/2-1.
REQ-019 PROC, palindrome: exit on the first mismatch (pal_ok=0) or after all pairs match (pal_ok=1), then go to REPORT.
REQ-020 PROC, pass and reverse: exit after one cycle.
REQ-021 EMIT, output index j=0..len-1: pass -> buf[j]; reverse -> buf[len-1-j]; rotate -> buf[(j+k) mod len] (k already reduced).
REQ-022 out_valid SHALL stay high in EMIT; out_data and out_last SHALL hold stable while out_valid&&!out_ready; j advances only on a handshake.
REQ-023 out_last SHALL be 1 only for j=len-1; the handshake on that beat returns the FSM to IDLE.
REQ-024 REPORT: pal_valid=1 for exactly one cycle, then go to IDLE; pal_ok holds until the next palindrome op.
REQ-025 busy SHALL be 1 in PROC, EMIT and REPORT; in_ready=0 in those states.
REQ-026 err SHALL be cleared on the first accepted beat of the next string.
REQ-027 rot_k=0 or rot_k=len SHALL give output identical to pass.

Reset
REQ-028 Asserting rst_n low SHALL go to IDLE immediately, in any state including mid-EMIT.
REQ-029 Reset values SHALL be: in_ready=0 while in reset (1 after release), out_valid=0, out_data=0, out_last=0, pal_valid=0, pal_ok=0, len_o=0, busy=0, err=0.
REQ-030 Buffer contents SHALL NOT be reset.

Configuration
REQ-031 Macro STR_CASE_FOLD_EN: when defined, the palindrome compare SHALL map 'A'..'Z' to 'a'..'z' before comparing.
REQ-032 Without STR_CASE_FOLD_EN, the palindrome compare SHALL be exact; EMIT data is never folded in either case.

Structure
REQ-033 Package str_op_pkg SHALL hold the op_e enum (OP_PASS, OP_REV, OP_ROT, OP_PAL), the state_e enum and a to_lower function.
REQ-034 One sub-module str_buf SHALL implement the MAX_LEN x CW buffer: one write port and two combinational read ports.

Verification
REQ-035 "Hello" with op=1 SHALL emit "olleH", out_last on 'H', len_o=5.
REQ-036 "System" with op=2, rot_k=2 SHALL emit "stemSy"; with rot_k=8 it SHALL emit "stemSy" after 2 cycles of PROC reduction.
REQ-037 "Madam" with op=3 SHALL give pal_valid with pal_ok=1 when STR_CASE_FOLD_EN is defined, and pal_ok=0 without it; "abca" SHALL give pal_ok=0 after a mismatch on the second compare.
REQ-038 33 beats with in_last on the 33rd and MAX_LEN=32 SHALL give err=1, len_o=32, and emit the first 32 characters for op=0.
REQ-039 op=0 "ABCD" with out_ready toggling every cycle SHALL emit "ABCD" with no duplicated or dropped beats and data stable while stalled.
REQ-040 rst_n pulsed low during EMIT of "ABCD" SHALL give out_valid=0 immediately; a following "xy" with op=1 SHALL emit "yx".
